vga_mem_arbiter: RTL and testbench

//  Single-port arbiter/scheduler for the shared frame memory (vgaMemory).

---
 rtl/vga_mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vga_mem_arbiter
//   Single-port arbiter for the shared frame memory. Serialises four clients
//   onto one RAM port, one access per cycle, in a single clock domain:
//     CAM  - camera pixel writer        (highest priority)
//     LB   - line-buffer filler (reads, may hold a burst lock)
//     CONV - convolution writeback      (round-robin with HPS)
//     HPS  - HPS image reader           (round-robin with CONV)
//   Read data is returned on a shared bus and tagged to its owner with rvalid.
//
// Ports
//   clk, reset                    clock, asynchronous active-high reset
//   cam_req/addr/wdata, cam_gnt   CAM write request / same-cycle grant
//   lb_req/lock/addr, lb_gnt      LB read request, burst lock / grant
//   lb_rvalid                     rdata belongs to LB this cycle
//   conv_req/addr/wdata, conv_gnt CONV write request / grant
//   hps_req/addr, hps_gnt         HPS read request / grant
//   hps_rvalid                    rdata belongs to HPS this cycle
//   rdata                         read data (mem_rdata passthrough)
//   mem_addr/wdata/we             registered RAM command
//   mem_rdata                     RAM read data
//   lock_active                   arbiter is in the LB-locked state
// -----------------------------------------------------------------------------
module vga_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 32,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cam_req,
    input  logic [AW-1:0] cam_addr,
    input  logic [DW-1:0] cam_wdata,
    output logic          cam_gnt,
    input  logic          lb_req,
    input  logic          lb_lock,
    input  logic [AW-1:0] lb_addr,
    output logic          lb_gnt,
    output logic          lb_rvalid,
    input  logic          conv_req,
    input  logic [AW-1:0] conv_addr,
    input  logic [DW-1:0] conv_wdata,
    output logic          conv_gnt,
    input  logic          hps_req,
    input  logic [AW-1:0] hps_addr,
    output logic          hps_gnt,
    output logic          hps_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          lock_active
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rr_hps;      // 1: HPS wins a CONV/HPS tie, 0: CONV wins
    logic [SW-1:0]   r_starve;
    logic [RD_LATENCY:0] r_lb_tag;
    logic [RD_LATENCY:0] r_hps_tag;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_mem_we;

    logic            w_lock_hold;
    logic            w_starved;
    logic            w_cam_gnt;
    logic            w_lb_gnt;
    logic            w_conv_gnt;
    logic            w_hps_gnt;

    // Grant selection and next-state decode
    always_comb begin
        w_cam_gnt   = 1'b0;
        w_lb_gnt    = 1'b0;
        w_conv_gnt  = 1'b0;
        w_hps_gnt   = 1'b0;
        w_state_nxt = r_state;
        // The lock only holds while lb_lock stays high; the cycle it drops
        // is already arbitrated with the idle rules.
        w_lock_hold = (r_state == ST_LOCKED) && lb_lock;
        w_starved   = (r_starve == STARVE_MAX);

        if (reset) begin
            // Grants are combinational, so they are forced low during reset.
            w_cam_gnt = 1'b0;
        end else if (w_lock_hold) begin
            if (cam_req && w_starved) begin
                w_cam_gnt = 1'b1;
            end else if (lb_req) begin
                w_lb_gnt = 1'b1;
            end else begin
                w_lb_gnt = 1'b0;
            end
        end else begin
            if (cam_req) begin
                w_cam_gnt = 1'b1;
            end else if (lb_req) begin
                w_lb_gnt = 1'b1;
            end else if (conv_req && hps_req) begin
                w_hps_gnt  = r_rr_hps;
                w_conv_gnt = ~r_rr_hps;
            end else if (conv_req) begin
                w_conv_gnt = 1'b1;
            end else if (hps_req) begin
                w_hps_gnt = 1'b1;
            end else begin
                w_conv_gnt = 1'b0;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_lb_gnt && lb_lock) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_lock_hold) begin
                    w_state_nxt = ST_LOCKED;
                end else if (w_lb_gnt && lb_lock) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin pointer: favour the other client after each CONV/HPS grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_hps <= 1'b0;
        end else if (w_conv_gnt) begin
            r_rr_hps <= 1'b1;
        end else if (w_hps_gnt) begin
            r_rr_hps <= 1'b0;
        end else begin
            r_rr_hps <= r_rr_hps;
        end
    end

    // CAM starvation counter: counts waiting cycles, saturates, clears on grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= {SW{1'b0}};
        end else if (w_cam_gnt) begin
            r_starve <= {SW{1'b0}};
        end else if (cam_req && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // RAM command register; reads and idle cycles leave wdata untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_addr  <= {AW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
            r_mem_we    <= 1'b0;
        end else if (w_cam_gnt) begin
            r_mem_addr  <= cam_addr;
            r_mem_wdata <= cam_wdata;
            r_mem_we    <= 1'b1;
        end else if (w_conv_gnt) begin
            r_mem_addr  <= conv_addr;
            r_mem_wdata <= conv_wdata;
            r_mem_we    <= 1'b1;
        end else if (w_lb_gnt) begin
            r_mem_addr  <= lb_addr;
            r_mem_we    <= 1'b0;
        end else if (w_hps_gnt) begin
            r_mem_addr  <= hps_addr;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
        end
    end

    // Read-owner tag pipes: one stage for the command register plus the RAM latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lb_tag  <= {(RD_LATENCY+1){1'b0}};
            r_hps_tag <= {(RD_LATENCY+1){1'b0}};
        end else begin
            r_lb_tag  <= {r_lb_tag[RD_LATENCY-1:0], w_lb_gnt};
            r_hps_tag <= {r_hps_tag[RD_LATENCY-1:0], w_hps_gnt};
        end
    end

    assign cam_gnt     = w_cam_gnt;
    assign lb_gnt      = w_lb_gnt;
    assign conv_gnt    = w_conv_gnt;
    assign hps_gnt     = w_hps_gnt;
    assign lb_rvalid   = r_lb_tag[RD_LATENCY];
    assign hps_rvalid  = r_hps_tag[RD_LATENCY];
    assign rdata       = mem_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign lock_active = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_mem_arbiter
//   Directed bench for vga_mem_arbiter with a 2-cycle-latency RAM model.
//   Expected read returns are queued when a read grant is expected and are
//   popped by a monitor when rvalid appears.
// -----------------------------------------------------------------------------
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cam_req, lb_req, lb_lock, conv_req, hps_req;
    logic [15:0] cam_addr, lb_addr, conv_addr, hps_addr;
    logic [31:0] cam_wdata, conv_wdata;
    logic        cam_gnt, lb_gnt, conv_gnt, hps_gnt;
    logic        lb_rvalid, hps_rvalid, mem_we, lock_active;
    logic [31:0] rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] mem_addr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic        is_lb;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ram [0:65535];
    logic [31:0] rd_s1 = 32'h0;

    vga_mem_arbiter #(.AW(16), .DW(32), .RD_LATENCY(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cam_req(cam_req), .cam_addr(cam_addr), .cam_wdata(cam_wdata), .cam_gnt(cam_gnt),
        .lb_req(lb_req), .lb_lock(lb_lock), .lb_addr(lb_addr), .lb_gnt(lb_gnt),
        .lb_rvalid(lb_rvalid),
        .conv_req(conv_req), .conv_addr(conv_addr), .conv_wdata(conv_wdata),
        .conv_gnt(conv_gnt),
        .hps_req(hps_req), .hps_addr(hps_addr), .hps_gnt(hps_gnt), .hps_rvalid(hps_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .lock_active(lock_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {~a, a ^ 16'h3C3C};
    endfunction

    // RAM model: address registered by the DUT, data two cycles later
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        rd_s1     <= ram[mem_addr];
        mem_rdata <= rd_s1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gvec();
        return {cam_gnt, lb_gnt, conv_gnt, hps_gnt};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic expect_read(input logic is_lb, input logic [15:0] a);
        sb.push_back('{due: cyc + 3, is_lb: is_lb, data: pat(a)});
    endtask

    task automatic drain();
        for (int k = 0; k < 8; k++) next_cycle();
    endtask

    // Read-return monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (lb_rvalid || hps_rvalid) begin
                if (sb.size() == 0) begin
                    check("rd_unexpected", {lb_rvalid, hps_rvalid}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("rd_cycle", cyc, e.due);
                    check("rd_owner", {lb_rvalid, hps_rvalid}, e.is_lb ? 2'b10 : 2'b01);
                    check("rd_data", rdata, e.data);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check("rd_missing", 1'b0, 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog timeout");
    end

    initial begin
        logic [15:0] la;
        logic [15:0] ha;
        logic        prev_conv;
        logic        cam_done;

        for (int i = 0; i < 65536; i++) ram[i] = pat(i[15:0]);

        // Reset with every request raised: nothing may be granted
        reset = 1'b1;
        cam_req = 1'b1; lb_req = 1'b1; lb_lock = 1'b1; conv_req = 1'b1; hps_req = 1'b1;
        cam_addr = 16'h0010; cam_wdata = 32'h1111_0010;
        lb_addr = 16'h0020; conv_addr = 16'h0030; conv_wdata = 32'h3333_0030;
        hps_addr = 16'h0040;
        #3;
        check("rst_gnt", gvec(), 4'b0000);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_lock", lock_active, 1'b0);
        check("rst_rvalid", {lb_rvalid, hps_rvalid}, 2'b00);
        next_cycle();
        next_cycle();
        reset = 1'b0; lb_lock = 1'b0;

        // 1: all four request -> CAM, then LB, then CONV, then HPS
        settle();
        check("t1_cam", gvec(), 4'b1000);
        next_cycle();
        cam_req = 1'b0;
        settle();
        check("t1_we_cam", mem_we, 1'b1);
        check("t1_addr_cam", mem_addr, 16'h0010);
        check("t1_wdata_cam", mem_wdata, 32'h1111_0010);
        check("t1_lb", gvec(), 4'b0100);
        expect_read(1'b1, 16'h0020);
        next_cycle();
        lb_req = 1'b0;
        settle();
        check("t1_we_lb", mem_we, 1'b0);
        check("t1_addr_lb", mem_addr, 16'h0020);
        check("t1_conv", gvec(), 4'b0010);
        next_cycle();
        conv_req = 1'b0;
        settle();
        check("t1_we_conv", mem_we, 1'b1);
        check("t1_addr_conv", mem_addr, 16'h0030);
        check("t1_hps", gvec(), 4'b0001);
        expect_read(1'b0, 16'h0040);
        next_cycle();
        hps_req = 1'b0;
        settle();
        check("t1_idle_gnt", gvec(), 4'b0000);
        check("t1_addr_hps", mem_addr, 16'h0040);
        next_cycle();
        settle();
        check("t1_hold_addr", mem_addr, 16'h0040);
        check("t1_hold_wdata", mem_wdata, 32'h3333_0030);
        check("t1_hold_we", mem_we, 1'b0);
        drain();

        // 2: CONV and HPS held -> C,H,C,H,C,H
        ha = 16'h0100;
        prev_conv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            conv_req = 1'b1; hps_req = 1'b1; hps_addr = ha;
            conv_addr = 16'h0200 + 16'(i); conv_wdata = 32'hC0DE_0000 + 32'(i);
            settle();
            check("t2_rr", gvec(), (i % 2 == 0) ? 4'b0010 : 4'b0001);
            if (i > 0) check("t2_we", mem_we, prev_conv);
            prev_conv = (i % 2 == 0);
            if (i % 2 == 1) begin
                expect_read(1'b0, ha);
                ha = ha + 16'h1;
            end
            next_cycle();
        end
        conv_req = 1'b0; hps_req = 1'b0;
        drain();

        // 3: LB lock for 20 cycles, CAM from cycle 2, CONV waiting throughout
        la = 16'h0300;
        cam_done = 1'b0;
        cam_addr = 16'h0400; cam_wdata = 32'h0000_CAFE;
        for (int j = 0; j < 20; j++) begin
            lb_req = 1'b1; lb_lock = 1'b1; lb_addr = la; conv_req = 1'b1;
            cam_req = (j >= 2) && !cam_done;
            settle();
            check("t3_gnt", gvec(), (j == 10) ? 4'b1000 : 4'b0100);
            check("t3_lock", lock_active, (j > 0) ? 1'b1 : 1'b0);
            if (j == 11) begin
                check("t3_cam_we", mem_we, 1'b1);
                check("t3_cam_addr", mem_addr, 16'h0400);
            end
            if (j == 10) begin
                cam_done = 1'b1;
            end else begin
                expect_read(1'b1, la);
                la = la + 16'h1;
            end
            next_cycle();
        end
        lb_req = 1'b0; lb_lock = 1'b0; cam_req = 1'b0;
        settle();
        check("t3_drop_gnt", gvec(), 4'b0010);
        check("t3_drop_lock", lock_active, 1'b1);
        next_cycle();
        conv_req = 1'b0;
        settle();
        check("t3_unlocked", lock_active, 1'b0);
        drain();

        // 4: CAM write 0x1234 / 0xA5
        cam_req = 1'b1; cam_addr = 16'h1234; cam_wdata = 32'h0000_00A5;
        settle();
        check("t4_gnt", gvec(), 4'b1000);
        next_cycle();
        cam_req = 1'b0;
        settle();
        check("t4_addr", mem_addr, 16'h1234);
        check("t4_wdata", mem_wdata, 32'h0000_00A5);
        check("t4_we", mem_we, 1'b1);
        next_cycle();
        settle();
        check("t4_we_off", mem_we, 1'b0);
        check("t4_addr_hold", mem_addr, 16'h1234);
        next_cycle();

        // 5: reset one cycle after an LB read grant drops the read
        lb_req = 1'b1; lb_lock = 1'b0; lb_addr = 16'h0500;
        settle();
        check("t5_gnt", gvec(), 4'b0100);
        next_cycle();
        reset = 1'b1; lb_req = 1'b0;
        settle();
        check("t5_rst_gnt", gvec(), 4'b0000);
        check("t5_rst_addr", mem_addr, 16'h0000);
        check("t5_rst_wdata", mem_wdata, 32'h0);
        check("t5_rst_we", mem_we, 1'b0);
        check("t5_rst_rvalid", {lb_rvalid, hps_rvalid}, 2'b00);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("t5_no_rvalid", lb_rvalid, 1'b0);
            next_cycle();
        end

        // 6: lock without grant has no effect; locked LB toggling blocks HPS
        cam_req = 1'b1; cam_addr = 16'h0800; cam_wdata = 32'h0000_0800;
        lb_req = 1'b1; lb_lock = 1'b1; lb_addr = 16'h0600;
        hps_req = 1'b1; hps_addr = 16'h0700;
        settle();
        check("t6_cam", gvec(), 4'b1000);
        next_cycle();
        cam_req = 1'b0;
        settle();
        check("t6_nolock", lock_active, 1'b0);
        check("t6_lb", gvec(), 4'b0100);
        expect_read(1'b1, 16'h0600);
        la = 16'h0601;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            lb_req = (k % 2 == 1); lb_addr = la;
            settle();
            check("t6_toggle", gvec(), lb_req ? 4'b0100 : 4'b0000);
            check("t6_lock", lock_active, 1'b1);
            if (lb_req) begin
                expect_read(1'b1, la);
                la = la + 16'h1;
            end
            next_cycle();
        end
        lb_lock = 1'b0; lb_req = 1'b0;
        settle();
        check("t6_hps", gvec(), 4'b0001);
        expect_read(1'b0, 16'h0700);
        next_cycle();
        hps_req = 1'b0;
        settle();
        check("t6_idle", gvec(), 4'b0000);

        for (int k = 0; k < 20 && sb.size() > 0; k++) next_cycle();
        check("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
